hd_out_ctrl: RTL
================

HD_OUT_CTRL -- requirements
Module: hd_out_ctrl

Interface
REQ-001 Parameters SHALL be: N_BITS, 533, codeword hard-decision width; MAX_ITER, 10, maximum decoder iterations (legal range 1..31).
REQ-002 Port sys_clk SHALL be an input, 1 bit wide, and is the single clock.
REQ-003 Port sys_rst_n SHALL be an input, 1 bit wide, and is the reset: synchronous and active-low.
REQ-004 Port flag_dec_start SHALL be an input, 1 bit wide: a one-cycle pulse that starts decoding a new codeword.
REQ-005 Port flag_VFU_end SHALL be an input, 1 bit wide: a one-cycle pulse marking the end of a variable-node pass.
REQ-006 Port bit_data_reg SHALL be an input, N_BITS wide: hard decisions, valid from the cycle after flag_VFU_end.
REQ-007 Port out_ready SHALL be an input, 1 bit wide: downstream byte acceptance.
REQ-008 Port flag_iter_next SHALL be an output, 1 bit wide: a one-cycle pulse requesting the next check/variable iteration.
REQ-009 Port flag_dec_done SHALL be an output, 1 bit wide: a one-cycle pulse when the decision is final.
REQ-010 Port flag_early_stop SHALL be an output, 1 bit wide: held high when the last decode terminated before MAX_ITER.
REQ-011 Port iter_cnt SHALL be an output, 5 bits wide: number of completed iterations for the current codeword.
REQ-012 Port out_data SHALL be an output, 8 bits wide: packed hard-decision byte.
REQ-013 Port out_valid SHALL be an output, 1 bit wide: out_data is valid.
REQ-014 Port out_last SHALL be an output, 1 bit wide: asserted with the final byte.
REQ-015 Port busy SHALL be an output, 1 bit wide: high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_END, CAPTURE, DECIDE and STREAM.
REQ-017 In IDLE, flag_dec_start SHALL clear iter_cnt to 0, clear the previous-decision register and flag_early_stop, and move to WAIT_END.
REQ-018 In WAIT_END, flag_VFU_end SHALL move the FSM to CAPTURE; all other inputs are ignored.
REQ-019 CAPTURE SHALL last exactly one cycle, latch bit_data_reg into the current-decision register, increment iter_cnt, and move to DECIDE.
REQ-020 DECIDE SHALL last exactly one cycle, with the following exits:
  - iter_cnt == MAX_ITER: go to STREAM, pulse flag_dec_done, flag_early_stop = 0.
  - stable-stop condition true (REQ-030): go to STREAM, pulse flag_dec_done, flag_early_stop = 1.
  - otherwise: copy current to previous, pulse flag_iter_next, return to WAIT_END.
REQ-021 flag_iter_next and flag_dec_done SHALL be registered outputs, high for exactly one cycle, in the cycle after DECIDE; they are never high together.
REQ-022 STREAM SHALL emit ceil(N_BITS/8) = 67 bytes; byte k = current[8k+7:8k], with current bit 8k mapped to out_data[0].
REQ-023 The final byte (k = 66) SHALL carry bits 532:528 in out_data[4:0], with out_data[7:5] = 0, and out_last = 1.
REQ-024 Handshake: a byte transfers on a cycle where out_valid && out_ready; out_data and out_last SHALL hold stable while out_valid && !out_ready; out_valid SHALL NOT drop until the transfer.
REQ-025 out_valid SHALL rise in the first STREAM cycle; back-to-back transfers proceed at 1 byte/cycle.
REQ-026 After the out_last transfer, the FSM SHALL return to IDLE on the next cycle, with out_valid = 0.
REQ-027 flag_dec_start outside IDLE SHALL be ignored; a stray flag_VFU_end outside WAIT_END SHALL be ignored.
REQ-028 iter_cnt and flag_early_stop SHALL hold their values after done until the next accepted flag_dec_start.

Reset
REQ-029 While sys_rst_n == 0 at a rising edge, the block SHALL enter IDLE, and every output and register SHALL go to 0 (iter_cnt = 0, out_valid = 0, busy = 0). Reset mid-STREAM aborts with no further bytes.

Configuration
REQ-030 Macro HD_STABLE_STOP_EN:
  - Defined: the stable-stop condition is current == previous && iter_cnt >= 2.
  - Undefined: the condition is constant 0, no previous-decision register is built, flag_early_stop is tied to 0, and termination occurs only at MAX_ITER.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
  - MAX_ITER=3, macro off, 3 VFU ends with varying data -> 2 flag_iter_next pulses, then flag_dec_done, iter_cnt = 3, 67 bytes.
  - Macro on, identical data on iterations 1 and 2 -> flag_dec_done after the 2nd capture, iter_cnt = 2, flag_early_stop = 1.
  - bit_data_reg = all ones -> bytes 0..65 = 0xFF, byte 66 = 0x1F with out_last.
  - out_ready toggling 1,0,0,1 during STREAM -> no byte lost or duplicated, out_data stable while stalled.
  - sys_rst_n low at byte 30 -> next cycle out_valid = 0, busy = 0, iter_cnt = 0.
  - flag_dec_start pulsed during STREAM -> ignored; the stream completes with 67 bytes.

Source files
------------

// File: rtl/hd_out_ctrl.sv
`timescale 1ns/1ps
// hd_out_ctrl: sequences decoder iterations, makes the stop decision, then streams the hard decision out as bytes.
// Optional macro HD_STABLE_STOP_EN: stop early once two consecutive decisions are identical.
module hd_out_ctrl #(
    parameter int N_BITS   = 533,
    parameter int MAX_ITER = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              flag_dec_start,
    input  logic              flag_VFU_end,
    input  logic [N_BITS-1:0] bit_data_reg,
    input  logic              out_ready,
    output logic              flag_iter_next,
    output logic              flag_dec_done,
    output logic              flag_early_stop,
    output logic [4:0]        iter_cnt,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy
);

    localparam int N_BYTES  = (N_BITS + 7) / 8;
    localparam int PAD_BITS = N_BYTES * 8;
    localparam int IDX_W    = $clog2(N_BYTES + 1);
    localparam logic [4:0]       MAX_ITER_V = 5'(MAX_ITER);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_BYTES - 1);

    typedef enum logic [2:0] {IDLE, WAIT_END, CAPTURE, DECIDE, STREAM} state_t;

    state_t              state, next_state;
    logic [N_BITS-1:0]   cur_dec;
    logic [PAD_BITS-1:0] cur_pad;
    logic [IDX_W-1:0]    byte_idx;
    logic                max_hit, stable_stop, finish;
    logic                iter_next_d, dec_done_d;

    assign max_hit = (iter_cnt == MAX_ITER_V);
    assign finish  = max_hit || stable_stop;

`ifdef HD_STABLE_STOP_EN
    logic [N_BITS-1:0] prev_dec;

    assign stable_stop = (cur_dec == prev_dec) && (iter_cnt >= 5'd2);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            prev_dec        <= '0;
            flag_early_stop <= 1'b0;
        end else if (state == IDLE && flag_dec_start) begin
            prev_dec        <= '0;
            flag_early_stop <= 1'b0;
        end else if (state == DECIDE) begin
            // A max-iteration exit wins over a simultaneous stable match.
            if (finish) flag_early_stop <= !max_hit;
            else        prev_dec        <= cur_dec;
        end
    end
`else
    assign stable_stop     = 1'b0;
    assign flag_early_stop = 1'b0;
`endif

    // NOTE: every variable in this block gets a default first so no path can infer a latch.
    always_comb begin
        next_state  = state;
        iter_next_d = 1'b0;
        dec_done_d  = 1'b0;
        case (state)
            IDLE:     if (flag_dec_start) next_state = WAIT_END;
            WAIT_END: if (flag_VFU_end)   next_state = CAPTURE;
            CAPTURE:  next_state = DECIDE;
            DECIDE: begin
                if (finish) begin
                    next_state = STREAM;
                    dec_done_d = 1'b1;
                end else begin
                    next_state  = WAIT_END;
                    iter_next_d = 1'b1;
                end
            end
            STREAM:   if (out_ready && byte_idx == LAST_IDX) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            // NOTE: the wide decision register is reset as well, so out_data reads 0 after reset.
            cur_dec        <= '0;
            iter_cnt       <= '0;
            byte_idx       <= '0;
            flag_iter_next <= 1'b0;
            flag_dec_done  <= 1'b0;
        end else begin
            state          <= next_state;
            flag_iter_next <= iter_next_d;
            flag_dec_done  <= dec_done_d;
            case (state)
                IDLE:    if (flag_dec_start) iter_cnt <= '0;
                CAPTURE: begin
                    cur_dec  <= bit_data_reg;
                    iter_cnt <= iter_cnt + 5'd1;
                end
                DECIDE:  byte_idx <= '0;
                STREAM:  if (out_ready) byte_idx <= byte_idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

    // Zero-extend to whole bytes so the last byte carries zeros above bit N_BITS-1.
    assign cur_pad   = PAD_BITS'(cur_dec);
    assign out_data  = cur_pad[{byte_idx, 3'b000} +: 8];
    assign out_valid = (state == STREAM);
    assign out_last  = out_valid && (byte_idx == LAST_IDX);
    assign busy      = (state != IDLE);

endmodule
